// File: rtl/neuron_parallel_pkg.sv
// Shared fixed-point types for the neuron family.
// Q format, activation kinds, FSM states and saturation limits.
package neuron_parallel_pkg;

  localparam int INTEGER_WIDTH  = 8;
  localparam int FRACTION_WIDTH = 8;
  localparam int Q_WIDTH        = INTEGER_WIDTH + FRACTION_WIDTH;

  typedef logic signed [Q_WIDTH-1:0] q_t;

  typedef enum logic [1:0] {
    RELU,
    LINEAR,
    LEAKY_RELU
  } activation_type;

  typedef enum logic [1:0] {
    IDLE,
    ACCUMULATE,
    ACTIVATE,
    OUTPUT
  } state_e;

  function automatic q_t q_max();
    return {1'b0, {(Q_WIDTH-1){1'b1}}};
  endfunction

  function automatic q_t q_min();
    return {1'b1, {(Q_WIDTH-1){1'b0}}};
  endfunction

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/neuron_activation.sv
// Combinational activation: wide sum to saturated Q value.
// Low fraction bits are floored away before clamping.
module neuron_activation
  import neuron_parallel_pkg::*;
#(
  parameter int             ACC_WIDTH    = 37,
  parameter int             SUM_FRACTION = 2 * FRACTION_WIDTH,
  parameter activation_type ACTIVATION   = RELU,
  parameter int             LEAKY_SHIFT  = 3
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  output q_t                          result
);

  localparam int DROP = SUM_FRACTION - FRACTION_WIDTH;
  localparam int TW   = ACC_WIDTH - DROP;

  logic signed [TW-1:0] t;
  logic signed [TW-1:0] s;
  logic signed [TW-1:0] hi;
  logic signed [TW-1:0] lo;

  always_comb begin
    hi = TW'(q_max());
    lo = TW'(q_min());
    t  = TW'(acc >>> DROP);
    s  = t;
    if (t < 0) begin
      case (ACTIVATION)
        LINEAR:     s = t;
        LEAKY_RELU: s = t >>> LEAKY_SHIFT;
        default:    s = '0;
      endcase
    end
    if (s > hi) begin
      s = hi;
    end else if (s < lo) begin
      s = lo;
    end
    result = s[Q_WIDTH-1:0];
  end

endmodule

// File: rtl/neuron_parallel.sv
// Fixed-point neuron with NUM_LANES parallel MACs per beat.
// Run-time weights/bias; valid/ready on both sides.
module neuron_parallel
  import neuron_parallel_pkg::*;
#(
  parameter int             NUM_INPUTS  = 16,
  parameter int             NUM_LANES   = 4,
  parameter activation_type ACTIVATION  = RELU,
  parameter int             LEAKY_SHIFT = 3,
  localparam int            ADDR_WIDTH  = max1($clog2(NUM_INPUTS))
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  inputs_valid,
  output logic                  inputs_ready,
  input  q_t                    inputs [NUM_INPUTS],
  input  logic                  weight_write,
  input  logic [ADDR_WIDTH-1:0] weight_address,
  input  q_t                    weight_data,
  input  logic                  bias_write,
  input  q_t                    bias_data,
  output q_t                    out,
  output logic                  output_valid,
  input  logic                  output_ready
);

  localparam int BEATS      = (NUM_INPUTS + NUM_LANES - 1) / NUM_LANES;
  localparam int BEAT_WIDTH = max1($clog2(BEATS));
  localparam int PAD_WIDTH  = max1($clog2(BEATS * NUM_LANES));
  localparam int PAD_N      = 2 ** PAD_WIDTH;
  localparam int PROD_WIDTH = 2 * Q_WIDTH;
  localparam int ACC_WIDTH  = 2 * INTEGER_WIDTH
                            + $clog2(NUM_INPUTS + 1)
                            + 2 * FRACTION_WIDTH;

  state_e                  state_q, state_d;
  logic [BEAT_WIDTH-1:0]   beat_q, beat_d;
  q_t                      in_buf_q [PAD_N];
  q_t                      in_buf_d [PAD_N];
  q_t                      weight_q [PAD_N];
  q_t                      weight_d [PAD_N];
  q_t                      bias_q, bias_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0] beat_sum;
  q_t                      out_q, out_d;
  q_t                      act_out;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic [PAD_WIDTH-1:0]    idx;
  logic signed [PROD_WIDTH-1:0] prod;

  // Buffers are padded to a power of two; slots past NUM_INPUTS stay zero.
  always_comb begin
    beat_sum = '0;
    idx      = '0;
    prod     = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      idx  = PAD_WIDTH'(int'(beat_q) * NUM_LANES + l);
      prod = PROD_WIDTH'(in_buf_q[idx]) * PROD_WIDTH'(weight_q[idx]);
      beat_sum = beat_sum + ACC_WIDTH'(prod);
    end
  end

  neuron_activation #(
    .ACC_WIDTH    (ACC_WIDTH),
    .SUM_FRACTION (2 * FRACTION_WIDTH),
    .ACTIVATION   (ACTIVATION),
    .LEAKY_SHIFT  (LEAKY_SHIFT)
  ) u_act (
    .acc    (acc_q),
    .result (act_out)
  );

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    in_buf_d    = in_buf_q;
    weight_d    = weight_q;
    bias_d      = bias_q;
    acc_d       = acc_q;
    out_d       = out_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (weight_write && int'(weight_address) < NUM_INPUTS) begin
          weight_d[PAD_WIDTH'(weight_address)] = weight_data;
        end
        if (bias_write) begin
          bias_d = bias_data;
        end
        if (inputs_valid) begin
          for (int i = 0; i < NUM_INPUTS; i++) begin
            in_buf_d[i] = inputs[i];
          end
          acc_d      = ACC_WIDTH'(bias_d) <<< FRACTION_WIDTH;
          beat_d     = '0;
          in_ready_d = 1'b0;
          state_d    = ACCUMULATE;
        end
      end
      ACCUMULATE: begin
        acc_d  = acc_q + beat_sum;
        beat_d = beat_q + BEAT_WIDTH'(1);
        if (beat_q == BEAT_WIDTH'(BEATS - 1)) begin
          state_d = ACTIVATE;
        end
      end
      ACTIVATE: begin
        out_d       = act_out;
        out_valid_d = 1'b1;
        state_d     = OUTPUT;
      end
      OUTPUT: begin
        if (output_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      bias_q      <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      for (int i = 0; i < PAD_N; i++) begin
        in_buf_q[i] <= '0;
        weight_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      bias_q      <= bias_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      in_buf_q    <= in_buf_d;
      weight_q    <= weight_d;
    end
  end

  assign inputs_ready = in_ready_q;
  assign output_valid = out_valid_q;
  assign out          = out_q;

endmodule
